// File: rtl/protocol_attributes_class.sv
// protocol_attributes_class: pipelined PlusFour (x+4 with x+1 OneMore callback) and combinational ShiftLeftOne via external callback
module protocol_attributes_class #(
  parameter int STARTUP_CYCLES = 2,
  parameter int STALL_RATE_WIDTH = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        rst_and_startup_done_out,
  input  logic                        PlusFour_valid_in,
  input  logic [31:0]                 PlusFour_x_in,
  output logic                        PlusFour_valid_out,
  output logic [31:0]                 PlusFour_result_out,
  output logic                        OneMore_valid_out,
  output logic [31:0]                 OneMore_a_out,
  input  logic                        ShiftLeftOne_valid_in,
  input  logic [31:0]                 ShiftLeftOne_x_in,
  output logic [31:0]                 ShiftLeftOne_result_out,
  output logic                        ShiftLeftCallback_valid_out,
  output logic [31:0]                 ShiftLeftCallback_a_out,
  output logic [4:0]                  ShiftLeftCallback_amt_out,
  input  logic [31:0]                 ShiftLeftCallback_result_in,
  output logic                        stall_rate_supported_out,
  input  logic                        stall_rate_valid_in,
  input  logic [STALL_RATE_WIDTH-1:0] stall_rate_in
);
  localparam int CW = $clog2(STARTUP_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          accept;
  logic          unused_stall;
  assign accept = PlusFour_valid_in & rst_and_startup_done_out;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt                      <= '0;
      rst_and_startup_done_out <= 1'b0;
      OneMore_valid_out        <= 1'b0;
      OneMore_a_out            <= '0;
      PlusFour_valid_out       <= 1'b0;
      PlusFour_result_out      <= '0;
    end else begin
      if (!rst_and_startup_done_out) begin
        cnt                      <= cnt + CW'(1);
        rst_and_startup_done_out <= cnt == CW'(STARTUP_CYCLES - 1);
      end
      OneMore_valid_out  <= accept;
      PlusFour_valid_out <= OneMore_valid_out;
      if (accept) OneMore_a_out <= PlusFour_x_in + 32'd1;
      if (OneMore_valid_out) PlusFour_result_out <= OneMore_a_out + 32'd3;
    end
  assign ShiftLeftCallback_valid_out = ShiftLeftOne_valid_in & rst_and_startup_done_out;
  assign ShiftLeftCallback_a_out     = ShiftLeftOne_x_in;
  assign ShiftLeftCallback_amt_out   = 5'd1;
  assign ShiftLeftOne_result_out     = ShiftLeftCallback_result_in;
  assign stall_rate_supported_out    = 1'b0;
  assign unused_stall                = ^{stall_rate_valid_in, stall_rate_in};
endmodule

// File: tb/tb_protocol_attributes_class.sv
// tb_protocol_attributes_class: randomized and directed checks against a call-level reference model
module tb_protocol_attributes_class;
  localparam int STARTUP = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic done, pf_vi, pf_vo, om_v, sl_vi, cb_v, sup, sr_v;
  logic [31:0] pf_x, pf_r, om_a, sl_x, sl_r, cb_a, cb_r;
  logic [4:0] cb_amt;
  logic [2:0] sr;
  int tests = 0, fails = 0;
  int edges;
  bit pend_v;
  logic [31:0] pend_x, om_last, pf_last;
  bit om_exp_v, pf_exp_v;
  always #5 clk = ~clk;
  assign cb_r = cb_a << cb_amt;
  protocol_attributes_class #(.STARTUP_CYCLES(STARTUP), .STALL_RATE_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .rst_and_startup_done_out(done),
    .PlusFour_valid_in(pf_vi), .PlusFour_x_in(pf_x),
    .PlusFour_valid_out(pf_vo), .PlusFour_result_out(pf_r),
    .OneMore_valid_out(om_v), .OneMore_a_out(om_a),
    .ShiftLeftOne_valid_in(sl_vi), .ShiftLeftOne_x_in(sl_x), .ShiftLeftOne_result_out(sl_r),
    .ShiftLeftCallback_valid_out(cb_v), .ShiftLeftCallback_a_out(cb_a),
    .ShiftLeftCallback_amt_out(cb_amt), .ShiftLeftCallback_result_in(cb_r),
    .stall_rate_supported_out(sup), .stall_rate_valid_in(sr_v), .stall_rate_in(sr));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic bit done_m();
    return edges >= STARTUP;
  endfunction
  task automatic check_outs();
    check("done", 32'(done), 32'(done_m()));
    check("om_valid", 32'(om_v), 32'(om_exp_v));
    check("om_a", om_a, om_last);
    check("pf_valid", 32'(pf_vo), 32'(pf_exp_v));
    check("pf_result", pf_r, pf_last);
    check("stall_sup", 32'(sup), 32'd0);
  endtask
  task automatic step(input bit pv, input logic [31:0] px, input bit sv, input logic [31:0] sx);
    bit acc;
    pf_vi = pv; pf_x = px; sl_vi = sv; sl_x = sx;
    sr_v = 1'($urandom); sr = 3'($urandom);
    #1;
    check("cb_valid", 32'(cb_v), 32'(sv & done_m()));
    check("cb_a", cb_a, sx);
    check("cb_amt", 32'(cb_amt), 32'd1);
    check("sl_result", sl_r, sx * 2);
    @(posedge clk);
    acc = pv && done_m();
    pf_exp_v = pend_v;
    if (pend_v) pf_last = pend_x + 32'd4;
    om_exp_v = acc;
    if (acc) om_last = px + 32'd1;
    pend_v = acc; pend_x = px;
    edges++;
    #1;
    check_outs();
    @(negedge clk);
  endtask
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    pf_vi = 0; sl_vi = 0;
    #1;
    edges = 0; pend_v = 0; om_exp_v = 0; pf_exp_v = 0; om_last = 0; pf_last = 0;
    check_outs();
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    pf_vi = 0; pf_x = 0; sl_vi = 0; sl_x = 0; sr_v = 0; sr = 0;
    do_reset(10);
    step(1, 32'd5, 1, 32'd7);
    step(1, 32'd6, 0, 32'd3);
    check("done_after_startup", 32'(done), 32'd1);
    for (int i = 0; i < 10; i++) step(1, 32'(i), 0, 32'(i));
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 32'hFFFFFFFF, 0, 0);
    step(1, 32'hFFFFFFFC, 0, 0);
    check("wrap_om", om_a, 32'hFFFFFFFD);
    step(0, 0, 0, 0);
    check("wrap_pf", pf_r, 32'h0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 32'(i));
    step(0, 0, 0, 32'h12345678);
    for (int i = 0; i < 40; i++) step(1'($urandom), $urandom, 1'($urandom), $urandom);
    for (int i = 0; i < 10; i++) step(1, $urandom, 1, $urandom);
    step(1, 32'd100, 0, 0);
    step(1, 32'd200, 0, 0);
    do_reset(3);
    step(1, 32'd300, 1, 32'd9);
    step(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(1, 32'd41, 0, 0);
    step(0, 0, 0, 0);
    check("post_reset_pf", pf_r, 32'd45);
    step(0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/protocol_attributes_class.md
Name: protocol_attributes_class

Overview:
- Fixed-function compute block with three latency-insensitive interfaces, with no backpressure anywhere.
- PlusFour is a pipelined method. It returns x+4 and issues a OneMore callback carrying x+1 for every call.
- ShiftLeftOne is a zero-latency method. It computes x<<1 by calling the external combinational ShiftLeftCallback with amt=1.
- Sits behind valid-only mailbox adapters in the system; it includes a stub stall-rate port for the common interface.

Parameters:
- STARTUP_CYCLES, 2, rising edges after rst deasserts before rst_and_startup_done_out asserts (min 1).
- STALL_RATE_WIDTH, 3, width of stall_rate_in.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rst_and_startup_done_out  out  1  high when out of reset and startup is complete.
- PlusFour_valid_in  in  1  call strobe, one call per cycle.
- PlusFour_x_in  in  32  argument x.
- PlusFour_valid_out  out  1  result strobe.
- PlusFour_result_out  out  32  x+4.
- OneMore_valid_out  out  1  callback strobe.
- OneMore_a_out  out  32  x+1.
- ShiftLeftOne_valid_in  in  1  call strobe.
- ShiftLeftOne_x_in  in  32  argument x.
- ShiftLeftOne_result_out  out  32  x<<1, combinational.
- ShiftLeftCallback_valid_out  out  1  external callback strobe.
- ShiftLeftCallback_a_out  out  32  value to shift.
- ShiftLeftCallback_amt_out  out  5  shift amount.
- ShiftLeftCallback_result_in  in  32  external result, same cycle.
- stall_rate_supported_out  out  1  constant 0.
- stall_rate_valid_in  in  1  ignored.
- stall_rate_in  in  STALL_RATE_WIDTH  ignored.

Behaviour:
- Reset, asynchronous: all pipeline valids, rst_and_startup_done_out, PlusFour_valid_out and OneMore_valid_out go to 0 immediately.
- Reset, data registers: reset to 0.
- Startup: a counter runs after rst falls. rst_and_startup_done_out is registered and rises on the STARTUP_CYCLES-th rising edge.
- Startup gating: valid_in on either method is ignored while rst_and_startup_done_out=0.
- PlusFour stage 1: a call accepted at edge N registers a=x+1 (mod 2^32). OneMore_valid_out=1 with OneMore_a_out=a during cycle N..N+1, asserted for exactly one cycle.
- PlusFour stage 2: at edge N+1, result=a+3 is registered. PlusFour_valid_out=1 with PlusFour_result_out=x+4 during the following cycle.
  - Latency: 1 cycle to OneMore, 2 cycles to result.
  - Back-to-back calls every cycle are fully pipelined; order is preserved.
  - The OneMore output of call k always precedes or coincides with the PlusFour result of call k.
- PlusFour data outputs while their valid is low: hold last value; consumers must not sample them.
- Wrap: x=0xFFFFFFFF gives a=0, result=3. x=0xFFFFFFFC gives result 0.
- ShiftLeftOne, purely combinational, no registers:
  - ShiftLeftCallback_valid_out = ShiftLeftOne_valid_in & done.
  - ShiftLeftCallback_a_out = ShiftLeftOne_x_in.
  - ShiftLeftCallback_amt_out = 1.
  - ShiftLeftOne_result_out = ShiftLeftCallback_result_in.
  - The result is valid in the same cycle as the call, so the caller samples it at the next rising edge.
- ShiftLeftOne when not called: ShiftLeftCallback_valid_out=0; a_out and amt_out still pass through.
- Independence: PlusFour and ShiftLeftOne run concurrently with no interaction. Simultaneous calls are both serviced.
- Reset mid-operation: in-flight PlusFour calls are discarded; no outputs are produced for them after reset.
- stall_rate: the input is never used; supported_out is tied to 0.

Test Plan:
- Reset for 10 cycles, release: rst_and_startup_done_out rises after STARTUP_CYCLES edges. PlusFour_valid_in pulsed before done -> no outputs.
- Stream x=0..9 on consecutive cycles: OneMore_a_out = 1..10 and PlusFour_result_out = 4..13, in order, one per cycle, with OneMore leading by 1 cycle.
- Calls x=0xFFFFFFFF and x=0xFFFFFFFC: OneMore returns 0 and 0xFFFFFFFD; PlusFour returns 3 and 0.
- ShiftLeftOne x=0..9, with an external callback implementing a<<amt: at each next edge result_out = 0,2,...,18; amt_out=1; callback valid follows valid_in.
- Concurrent PlusFour and ShiftLeftOne calls every cycle: both produce correct results with no cross-interference.
- Assert rst while 2 PlusFour calls are in flight: valids drop immediately; after re-startup no stale results appear.
